// File: rtl/number_row.sv
// number_row: renders one 16-character LCD row showing a captured value
// in binary, hex, octal or decimal, with a background double-dabble.
module number_row #(
    parameter int VALUE_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [VALUE_WIDTH-1:0] i_value,
    input  logic [1:0]             i_mode,
    input  logic                   i_load,
    output logic                   o_busy,
    output logic                   o_done,
    input  logic [3:0]             i_charIndex,
    output logic [7:0]             o_character
);

    if (VALUE_WIDTH < 1 || VALUE_WIDTH > 12) begin : g_bad_width
        $error("number_row: VALUE_WIDTH must be in 1..12");
    end

    localparam logic [1:0] MODE_BIN = 2'd0;
    localparam logic [1:0] MODE_HEX = 2'd1;
    localparam logic [1:0] MODE_DEC = 2'd2;
    localparam logic [1:0] MODE_OCT = 2'd3;

    localparam logic [4:0] N_BIN = 5'(VALUE_WIDTH);
    localparam logic [4:0] N_HEX = 5'((VALUE_WIDTH + 3) / 4);
    localparam logic [4:0] N_OCT = 5'((VALUE_WIDTH + 2) / 3);
    localparam logic [4:0] N_DEC = (VALUE_WIDTH <= 3) ? 5'd1 :
                                   (VALUE_WIDTH <= 6) ? 5'd2 :
                                   (VALUE_WIDTH <= 9) ? 5'd3 : 5'd4;

    localparam logic [3:0] LAST_SHIFT = 4'(VALUE_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [VALUE_WIDTH-1:0] wval_q, wval_d;
    logic [1:0]             wmode_q, wmode_d;
    logic [15:0]            bcd_q, bcd_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [1:0]             cmode_q, cmode_d;
    logic [15:0]            cres_q, cres_d;
    logic                   done_q, done_d;
    logic [7:0]             char_q, char_d;
    logic [15:0]            bcd_adj;

    // Add 3 to every BCD nibble that is 5 or more ahead of the shift.
    function automatic logic [15:0] dd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    assign bcd_adj = dd_adjust(bcd_q);

    // State and datapath registers; reset leaves a committed binary zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            wval_q  <= '0;
            wmode_q <= MODE_BIN;
            bcd_q   <= '0;
            cnt_q   <= '0;
            cmode_q <= MODE_BIN;
            cres_q  <= '0;
            done_q  <= 1'b0;
            char_q  <= 8'h20;
        end else begin
            state_q <= state_d;
            wval_q  <= wval_d;
            wmode_q <= wmode_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            cmode_q <= cmode_d;
            cres_q  <= cres_d;
            done_q  <= done_d;
            char_q  <= char_d;
        end
    end

    // Capture, convert, then commit the working result in a single step.
    always_comb begin
        state_d = state_q;
        wval_d  = wval_q;
        wmode_d = wmode_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        cmode_d = cmode_q;
        cres_d  = cres_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_load) begin
                    wval_d  = i_value;
                    wmode_d = i_mode;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (wmode_q != MODE_DEC) begin
                    state_d = S_COMMIT;
                end else begin
                    {bcd_d, wval_d} = {bcd_adj, wval_q} << 1;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_SHIFT) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                cmode_d = wmode_q;
                if (wmode_q == MODE_DEC) begin
                    cres_d = bcd_q;
                end else begin
                    cres_d = '0;
                    cres_d[VALUE_WIDTH-1:0] = wval_q;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    logic [31:0] label;
    logic [4:0]  nfield;
    logic [3:0]  dig;
    logic [15:0] shifted;
    logic [7:0]  digit;
    logic        in_field;

    // Look up one row character from the committed registers only.
    always_comb begin
        label   = "Bin:";
        nfield  = N_BIN;
        shifted = '0;
        digit   = 8'h20;
        char_d  = 8'h20;
        dig     = 4'd15 - i_charIndex;
        unique case (cmode_q)
            MODE_BIN: begin
                label   = "Bin:";
                nfield  = N_BIN;
                shifted = cres_q >> dig;
                digit   = shifted[0] ? 8'h31 : 8'h30;
            end
            MODE_HEX: begin
                label   = "Hex:";
                nfield  = N_HEX;
                shifted = cres_q >> {dig, 2'b00};
                digit   = hex_ascii(shifted[3:0]);
            end
            MODE_DEC: begin
                label   = "Dec:";
                nfield  = N_DEC;
                shifted = cres_q >> {dig, 2'b00};
                if (dig != 4'd0 && shifted == 16'd0) begin
                    digit = 8'h20;
                end else begin
                    digit = hex_ascii(shifted[3:0]);
                end
            end
            MODE_OCT: begin
                label   = "Oct:";
                nfield  = N_OCT;
                shifted = cres_q >> (6'(dig) * 6'd3);
                digit   = hex_ascii({1'b0, shifted[2:0]});
            end
            default: begin
                label = "Bin:";
            end
        endcase
        // The label and separator keep their places even for a 12-bit binary field.
        in_field = (i_charIndex >= 4'd5) &&
                   ({1'b0, i_charIndex} >= (5'd16 - nfield));
        unique case (1'b1)
            (i_charIndex < 4'd4): begin
                unique case (i_charIndex[1:0])
                    2'd0:    char_d = label[31:24];
                    2'd1:    char_d = label[23:16];
                    2'd2:    char_d = label[15:8];
                    default: char_d = label[7:0];
                endcase
            end
            in_field: char_d = digit;
            default:  char_d = 8'h20;
        endcase
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_character = char_q;

endmodule
